// File: rtl/mesh_ep_pkg.sv
// Shared constants, types and helpers for the mesh edge endpoint.
// Packet field offsets are counted down from the packet MSB.
package mesh_ep_pkg;

  localparam int unsigned NxtJumpW  = 8;
  localparam int unsigned IdW       = 4;
  localparam int unsigned RowHiOff  = 8;
  localparam int unsigned ColHiOff  = 12;
  localparam int unsigned ModeOff   = 16;
  localparam int unsigned HeaderW   = 17;
  localparam logic [15:0] LfsrTaps  = 16'hB400;

  typedef struct packed {
    logic [IdW-1:0] row;
    logic [IdW-1:0] col;
  } coord_t;

  // Edge index order: top row, left column, bottom row, right column.
  function automatic coord_t edge_coord(input logic [7:0] sel, input int unsigned rows,
                                        input int unsigned cols);
    int unsigned idx;
    coord_t c;
    idx = {24'd0, sel} % (2 * (rows + cols));
    if (idx < cols) begin
      c.row = '0;
      c.col = IdW'(idx + 1);
    end else if (idx < cols + rows) begin
      c.row = IdW'(idx - cols + 1);
      c.col = '0;
    end else if (idx < 2 * cols + rows) begin
      c.row = IdW'(rows + 1);
      c.col = IdW'(idx - cols - rows + 1);
    end else begin
      c.row = IdW'(idx - 2 * cols - rows + 1);
      c.col = IdW'(cols + 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/ep_fifo.sv
// Show-ahead FIFO: rdata always presents the head entry; push into a full
// FIFO and pop from an empty FIFO are ignored.
module ep_fifo #(
  parameter int unsigned Width = 40,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned Aw = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wr_q, rd_q;
  logic [Aw:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == Depth[Aw:0]);
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/agente_driver_monitor.sv
// Mesh edge endpoint: packet generator, injection FIFO and output monitor.
// Define MONITOR_CHECK_EN to check received packet addresses against SELF.
module agente_driver_monitor
  import mesh_ep_pkg::*;
#(
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 4,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLUMS     = 4,
  parameter int unsigned SELF_ROW   = 0,
  parameter int unsigned SELF_COL   = 1,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         cant_datos,
  input  logic               id_rand,
  input  logic [3:0]         id_row,
  input  logic [3:0]         id_colum,
  output logic [pckg_sz-1:0] data_out_i_in,
  output logic               pndng_i_in,
  input  logic               popin,
  input  logic [pckg_sz-1:0] data_out,
  input  logic               pndng,
  output logic               pop,
  output logic               busy,
  output logic [15:0]        sent_cnt,
  output logic [15:0]        rcv_cnt,
  output logic [15:0]        err_cnt
);

  logic [7:0]         remaining_q;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [15:0]        sent_q, rcv_q;
  logic               pop_q;
  logic               fifo_full, fifo_empty, push;
  logic [pckg_sz-1:0] pkt, fifo_head;
  coord_t             dest;
  logic               unused_data;

  assign busy     = (remaining_q != '0);
  assign push     = busy && !fifo_full;
  assign lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
  assign sent_cnt = sent_q;
  assign rcv_cnt  = rcv_q;
  assign pop      = pop_q;
  assign unused_data = ^data_out;

  always_comb begin
    dest = '0;
    pkt  = '0;
    if (id_rand) begin
      dest = edge_coord(lfsr_q[7:0], ROWS, COLUMS);
    end else begin
      dest.row = id_row;
      dest.col = id_colum;
    end
    // Never address ourselves: mirror the coordinate instead.
    if (dest.row == SELF_ROW[IdW-1:0] && dest.col == SELF_COL[IdW-1:0]) begin
      dest = '{row: dest.col, col: dest.row};
    end
    pkt[pckg_sz-1-RowHiOff -: IdW] = dest.row;
    pkt[pckg_sz-1-ColHiOff -: IdW] = dest.col;
    pkt[pckg_sz-1-ModeOff]         = lfsr_q[0];
    for (int i = 0; i < int'(pckg_sz - HeaderW); i++) begin
      pkt[i] = lfsr_q[i % 16];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      remaining_q <= '0;
      lfsr_q      <= SEED;
      sent_q      <= '0;
    end else begin
      if (start && !busy) begin
        remaining_q <= cant_datos;
      end else if (push) begin
        remaining_q <= remaining_q - 8'd1;
      end
      if (push) begin
        lfsr_q <= lfsr_d;
        if (sent_q != 16'hFFFF) sent_q <= sent_q + 16'd1;
      end
    end
  end

  ep_fifo #(
    .Width (pckg_sz),
    .Depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (pkt),
    .pop   (popin),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pndng_i_in    = !fifo_empty;
  assign data_out_i_in = fifo_empty ? '0 : fifo_head;

  always_ff @(posedge clk) begin
    if (reset) begin
      pop_q <= 1'b0;
      rcv_q <= '0;
    end else if (pndng && !pop_q) begin
      pop_q <= 1'b1;
      if (rcv_q != 16'hFFFF) rcv_q <= rcv_q + 16'd1;
    end else begin
      pop_q <= 1'b0;
    end
  end

`ifdef MONITOR_CHECK_EN
  logic [15:0] err_q;
  logic        addr_bad;

  assign addr_bad = (data_out[pckg_sz-1-RowHiOff -: IdW] != SELF_ROW[IdW-1:0]) ||
                    (data_out[pckg_sz-1-ColHiOff -: IdW] != SELF_COL[IdW-1:0]);
  assign err_cnt  = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else if (pndng && !pop_q && addr_bad && err_q != 16'hFFFF) begin
      err_q <= err_q + 16'd1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_agente_driver_monitor.sv
// Directed bench for agente_driver_monitor: injected packets are predicted into
// a scoreboard queue at command time and compared as the FIFO is drained.
module tb_agente_driver_monitor;

  localparam int          W    = 40;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          reset, start, id_rand, popin, pndng;
  logic [7:0]    cant_datos;
  logic [3:0]    id_row, id_colum;
  logic [W-1:0]  data_out_i_in, data_out;
  logic          pndng_i_in, pop, busy;
  logic [15:0]   sent_cnt, rcv_cnt, err_cnt;

  int            total = 0;
  int            bad   = 0;
  logic [W-1:0]  exp_q[$];
  logic [15:0]   m_lfsr;

  agente_driver_monitor dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cant_datos    (cant_datos),
    .id_rand       (id_rand),
    .id_row        (id_row),
    .id_colum      (id_colum),
    .data_out_i_in (data_out_i_in),
    .pndng_i_in    (pndng_i_in),
    .popin         (popin),
    .data_out      (data_out),
    .pndng         (pndng),
    .pop           (pop),
    .busy          (busy),
    .sent_cnt      (sent_cnt),
    .rcv_cnt       (rcv_cnt),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_pkt(input logic [3:0] r, input logic [3:0] c,
                                          input logic [15:0] l);
    logic [W-1:0] p;
    logic [3:0]   t;
    if (r == 4'd0 && c == 4'd1) begin
      t = r; r = c; c = t;
    end
    p = '0;
    p[31:28] = r;
    p[27:24] = c;
    p[23]    = l[0];
    p[22:0]  = {l[6:0], l};
    return p;
  endfunction

  function automatic logic [7:0] rand_dest(input logic [15:0] l);
    int idx;
    idx = int'(l[7:0]) % 16;
    if (idx < 4)       return {4'd0, 4'(idx + 1)};
    else if (idx < 8)  return {4'(idx - 3), 4'd0};
    else if (idx < 12) return {4'd5, 4'(idx - 7)};
    else               return {4'(idx - 11), 4'd5};
  endfunction

  function automatic logic valid_edge(input logic [3:0] r, input logic [3:0] c);
    logic on_edge;
    on_edge = ((r == 0 || r == 5) && c >= 1 && c <= 4) ||
              ((c == 0 || c == 5) && r >= 1 && r <= 4);
    return on_edge && !(r == 0 && c == 1);
  endfunction

  task automatic enqueue(input int n, input logic rnd, input logic [3:0] r,
                         input logic [3:0] c);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd ? rand_dest(m_lfsr) : {r, c};
      exp_q.push_back(mk_pkt(d[7:4], d[3:0], m_lfsr));
      if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
      else           m_lfsr = m_lfsr >> 1;
    end
  endtask

  task automatic drain(input logic rnd_chk);
    logic [W-1:0] e;
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 300) begin
      if (pndng_i_in) begin
        e = exp_q.pop_front();
        check("fifo_head", data_out_i_in, e);
        if (rnd_chk) check("rand_valid", valid_edge(data_out_i_in[31:28], data_out_i_in[27:24]), 1);
        popin = 1'b1;
        tick();
        popin = 1'b0;
      end else begin
        tick();
      end
      guard++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic issue(input int n, input logic rnd, input logic [3:0] r, input logic [3:0] c);
    cant_datos = 8'(n);
    id_rand    = rnd;
    id_row     = r;
    id_colum   = c;
    start      = 1'b1;
    enqueue(n, rnd, r, c);
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; id_rand = 1'b0; popin = 1'b0; pndng = 1'b0;
    cant_datos = '0; id_row = '0; id_colum = '0; data_out = '0;
    m_lfsr = SEED;

    repeat (5) tick();
    check("rst_pndng", pndng_i_in, 0);
    check("rst_data", data_out_i_in, 0);
    check("rst_pop", pop, 0);
    check("rst_busy", busy, 0);
    check("rst_cnts", {sent_cnt, rcv_cnt, err_cnt}, 0);
    reset = 1'b0;

    // Three fixed-destination packets, FIFO not popped.
    issue(3, 1'b0, 4'd5, 4'd2);
    check("load_busy", busy, 1);
    check("load_pndng", pndng_i_in, 0);
    tick();
    check("first_push_pndng", pndng_i_in, 1);
    tick();
    tick();
    check("burst3_busy", busy, 0);
    check("burst3_sent", sent_cnt, 3);
    tick();
    check("burst3_sent_hold", sent_cnt, 3);
    drain(1'b0);
    check("empty_pndng", pndng_i_in, 0);
    check("empty_data", data_out_i_in, 0);

    // Six packets into a four-entry FIFO: agent stalls until popped.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_lfsr = SEED;
    issue(6, 1'b0, 4'd5, 4'd2);
    repeat (6) tick();
    check("stall_sent", sent_cnt, 4);
    check("stall_busy", busy, 1);
    drain(1'b0);
    check("stall_sent_final", sent_cnt, 6);
    check("stall_busy_final", busy, 0);

    // Destination equal to self is mirrored.
    issue(2, 1'b0, 4'd0, 4'd1);
    repeat (3) tick();
    drain(1'b0);

    // Random destinations.
    issue(20, 1'b1, 4'd0, 4'd0);
    drain(1'b1);
    check("rand_sent", sent_cnt, 28);

    // Monitor: matching address then mismatching address.
    data_out = mk_pkt(4'd1, 4'd0, 16'h1234);
    data_out[31:28] = 4'd0;
    data_out[27:24] = 4'd1;
    pndng = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mon_pop_ok", pop, (i % 2 == 0) ? 1 : 0);
    end
    check("mon_rcv_ok", rcv_cnt, 3);
    check("mon_err_ok", err_cnt, 0);
    data_out[31:28] = 4'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mon_pop_bad", pop, (i % 2 == 0) ? 1 : 0);
    end
    check("mon_rcv_bad", rcv_cnt, 5);
`ifdef MONITOR_CHECK_EN
    check("mon_err_bad", err_cnt, 2);
`else
    check("mon_err_bad", err_cnt, 0);
`endif
    pndng = 1'b0;
    tick();
    tick();
    check("mon_idle_pop", pop, 0);
    check("mon_idle_rcv", rcv_cnt, 5);

    // Reset in the middle of a burst.
    issue(10, 1'b0, 4'd5, 4'd2);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    m_lfsr = SEED;
    check("midrst_pndng", pndng_i_in, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cnts", {sent_cnt, rcv_cnt}, 0);
    tick();
    check("midrst_after_busy", busy, 0);
    check("midrst_after_pndng", pndng_i_in, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
